// File: rtl/request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : request_queue
//  Description : Consumer end of the trace-parser interface. Owns the CPU-time
//                base and buffers time-released requests in a FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module request_queue #(
   parameter int QUEUE_DEPTH   = 16,
   parameter int ADDRESS_WIDTH = 33,
   parameter int TIME_WIDTH    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_op_ready_s,
   input  logic [1:0]                   in_opcode,
   input  logic [ADDRESS_WIDTH-1:0]     in_address,
   input  logic [TIME_WIDTH-1:0]        in_time_cpu,
   output logic [TIME_WIDTH-1:0]        queue_time,
   output logic                         queue_full,
   output logic                         pending_request,
   input  logic                         deq_ready,
   output logic                         deq_valid,
   output logic [1:0]                   deq_opcode,
   output logic [ADDRESS_WIDTH-1:0]     deq_address,
   output logic [TIME_WIDTH-1:0]        deq_time_in,
   output logic [$clog2(QUEUE_DEPTH):0] occupancy
);

   localparam int               PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int               OCC_W   = PTR_W + 1;
   localparam logic [1:0]       OP_NOP  = 2'd3;
   localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(QUEUE_DEPTH);

   if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_depth_check
      $fatal(1, "request_queue: QUEUE_DEPTH must be a power of 2 (>= 2)");
   end

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [TIME_WIDTH-1:0]   time_q, time_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]        occ_q, occ_d;
   logic                    pend_q, pend_d;

   logic [1:0]              op_mem   [QUEUE_DEPTH];
   logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_DEPTH];
   logic [TIME_WIDTH-1:0]   time_mem [QUEUE_DEPTH];

   logic                    valid_op;
   logic                    pop;
   logic                    push;
   logic                    skip;
   logic                    full;
   logic [TIME_WIDTH:0]     time_plus1;

   assign full       = (occ_q == C_DEPTH);
   assign valid_op   = in_op_ready_s && (in_opcode != OP_NOP);
   assign pop        = (occ_q != '0) && deq_ready;
   assign push       = valid_op && (time_q >= in_time_cpu) && (!full || pop);
   // Extra bit keeps the skip-ahead compare honest when time_q is all-ones.
   assign time_plus1 = {1'b0, time_q} + {{TIME_WIDTH{1'b0}}, 1'b1};
   assign skip       = (state_q == S_IDLE) && (occ_q == '0) && valid_op &&
                       ({1'b0, in_time_cpu} > time_plus1);

   always_comb begin
      state_d  = state_q;
      time_d   = time_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pend_d   = valid_op && !push;

      if (skip) begin
         time_d = in_time_cpu;
      end else if (time_q != '1) begin
         time_d = time_plus1[TIME_WIDTH-1:0];
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (valid_op) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if ((occ_d == '0) && !valid_op) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         time_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         pend_q   <= pend_d;
      end
   end

   // Storage is deliberately left out of reset; occupancy gates validity.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr_q]   <= in_opcode;
         addr_mem[wr_ptr_q] <= in_address;
         time_mem[wr_ptr_q] <= time_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && full));
         assert (!(pop && !push && (occ_q == '0)));
         assert (occ_q <= C_DEPTH);
      end
   end

   assign queue_time      = time_q;
   assign queue_full      = full;
   assign pending_request = pend_q;
   assign deq_valid       = (occ_q != '0);
   assign deq_opcode      = op_mem[rd_ptr_q];
   assign deq_address     = addr_mem[rd_ptr_q];
   assign deq_time_in     = time_mem[rd_ptr_q];
   assign occupancy       = occ_q;

endmodule
`default_nettype wire

// File: doc/request_queue.md
Name: request_queue

Overview:
- Consumer end of the trace-parser interface.
- Accepts parsed CPU requests (opcode, address, CPU time) when simulated time has reached the request's timestamp, and buffers them in a 16-entry FIFO for the DRAM scheduler.
- Returns the flow-control signals the parser depends on: queue_time, queue_full and pending_request.
- Owns the simulation time base (CPU-clock cycle counter), including a skip-ahead when the controller is idle.

Parameters:
- QUEUE_DEPTH, 16, number of FIFO entries; must be a power of 2 (elaboration $fatal otherwise).
- ADDRESS_WIDTH, 33, request address width; matches global_defs.
- TIME_WIDTH, 32, width of queue_time and timestamps.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  asynchronous, active-high reset.
- in_op_ready_s  in  1  parser has an operation on its outputs.
- in_opcode  in  2  parsed_op_t: 0 READ, 1 WRITE, 2 IFETCH, 3 NOP.
- in_address  in  ADDRESS_WIDTH  request address.
- in_time_cpu  in  TIME_WIDTH  CPU time at which the request arrives.
- queue_time  out  TIME_WIDTH  current simulated CPU time.
- queue_full  out  1  occupancy == QUEUE_DEPTH.
- pending_request  out  1  presented operation not yet accepted (registered).
- deq_ready  in  1  scheduler pops head this cycle.
- deq_valid  out  1  head entry valid (occupancy != 0).
- deq_opcode  out  2  head opcode.
- deq_address  out  ADDRESS_WIDTH  head address.
- deq_time_in  out  TIME_WIDTH  queue_time value when the head was enqueued.
- occupancy  out  $clog2(QUEUE_DEPTH)+1  entries held.

Behaviour:
- Reset (async, immediate):
  - queue_time, wr_ptr, rd_ptr, occupancy and pending_request all go to 0.
  - Therefore queue_full=0 and deq_valid=0.
  - Storage array is not cleared. Reset asserted mid-operation discards all entries and any pending request.
- Definitions:
  - valid_op = in_op_ready_s && in_opcode != NOP.
  - pop = deq_valid && deq_ready.
  - push = valid_op && queue_time >= in_time_cpu && (!queue_full || pop).
- FSM, registered, states IDLE / ACTIVE:
  - IDLE: occupancy 0 and no pending request. Goes to ACTIVE on valid_op.
  - ACTIVE: returns to IDLE when the next occupancy is 0 and no valid_op is present.
- Time base:
  - Each cycle, queue_time <= queue_time+1, saturating at all-ones.
  - Skip-ahead: in IDLE with occupancy 0 and valid_op && in_time_cpu > queue_time+1, load queue_time <= in_time_cpu instead of incrementing. The op is pushed on the following edge.
- Push:
  - At the edge, write {opcode, address, queue_time} at wr_ptr.
  - wr_ptr wraps mod QUEUE_DEPTH.
  - Entry is visible on deq_* the cycle after the push (1-cycle latency).
  - A push into an empty queue is never bypassed to deq_* in the same cycle.
- Pop:
  - Head outputs are combinational from rd_ptr.
  - On pop, rd_ptr increments and wraps mod QUEUE_DEPTH.
  - deq_* values are don't-care while deq_valid=0; the scheduler must ignore them.
- Simultaneous push and pop: occupancy unchanged. Allowed when full (pop frees the slot the push fills). Push-when-full without pop is blocked.
- Occupancy: +1 on push only, -1 on pop only. Never exceeds QUEUE_DEPTH or goes below 0; assertion fires on violation.
- pending_request:
  - Registered: pending_request <= valid_op && !push. No combinational path from in_op_ready_s to pending_request.
  - Parser-side rule: the parser holds its outputs stable while pending_request=1 and only advances after it is 0.
- queue_full: combinational from occupancy register only. Independent of the same-cycle pop.
- Opcode values 3 (NOP) are ignored: never enqueued, never raise pending_request.
- Ordering: strict FIFO; no reordering or merging of same-address requests.

Test Plan:
- Reset: assert rst asynchronously between edges → all outputs 0 immediately. Release → queue_time counts 1, 2, 3 on subsequent edges.
- Single push: queue_time=5, present READ addr 0x1_0000_0040, time_cpu 3 → accepted at the edge. Next cycle: deq_valid=1, deq_opcode=0, deq_address=0x1_0000_0040, deq_time_in=5, occupancy=1, pending_request=0.
- Future request: queue holds 1 entry, deq_ready=0, queue_time=4, present WRITE time_cpu 20 → pending_request=1 from cycle 5. Accepted on the edge where queue_time==20. pending_request=0 the cycle after; occupancy=2.
- Idle skip-ahead: empty queue, queue_time=10, present IFETCH time_cpu 1000 → next cycle queue_time=1000. Entry pushed on that edge; deq_time_in=1000.
- Full + simultaneous push and pop:
  - With deq_ready=0, push 16 ops (addresses 0..15) → queue_full=1; the 17th op raises pending_request.
  - Pulse deq_ready one cycle → head addr 0 popped, 17th pushed at the same edge; occupancy stays 16.
  - Drain → addresses 1..16 emerge in order; pointer wrap is exercised.
- Mid-fill reset: 7 entries queued, pending_request=1, assert rst → occupancy=0, deq_valid=0, pending_request=0, queue_time=0 immediately. The held op is re-accepted after release.
